// File: rtl/subpel_pkg.sv
// rtl/subpel_pkg.sv - shared sizes, types and index helper for the subpixel reference path
package subpel_pkg;

    localparam int NUM_PIXEL_DEF = 8;
    localparam int WIN_DEF       = NUM_PIXEL_DEF + 7;
    localparam int TAPS          = 8;

    typedef logic [7:0]  pixel_t;
    typedef logic [63:0] tap_vec_t;

    typedef enum logic {
        LOAD,
        DRAIN
    } ld_state_t;

    // Increment an 8-bit index, wrapping to 0 after max.
    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
        return (v == max) ? 8'd0 : v + 8'd1;
    endfunction

endpackage

// File: rtl/window_bank.sv
// rtl/window_bank.sv - WIN x WIN pixel store with one write port and an 8-tap horizontal read mux
module window_bank
    import subpel_pkg::*;
#(
    parameter  int NUM_PIXEL = NUM_PIXEL_DEF,
    parameter  int PIX_W     = 8,
    localparam int WIN       = NUM_PIXEL + 7,
    localparam int IDX_W     = $clog2(WIN)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_row,
    input  logic [IDX_W-1:0]      wr_col,
    input  logic [PIX_W-1:0]      wr_data,
    input  logic [IDX_W-1:0]      rd_row,
    input  logic [IDX_W-1:0]      rd_col,
    output logic [TAPS*PIX_W-1:0] rd_tap
);

    logic [PIX_W-1:0] mem [WIN][WIN];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Tap k comes from column rd_col+k; tap 0 lands in the low byte.
    always_comb begin
        rd_tap = '0;
        for (int k = 0; k < TAPS; k++) begin
            rd_tap[k*PIX_W +: PIX_W] = mem[rd_row][rd_col + IDX_W'(k)];
        end
    end

endmodule

// File: rtl/ref_window_loader.sv
// rtl/ref_window_loader.sv - raster pixel loader draining 8-tap FIR vectors; REF_WINDOW_LOADER_PING_PONG_EN adds a second bank
module ref_window_loader
    import subpel_pkg::*;
#(
    parameter int NUM_PIXEL = NUM_PIXEL_DEF,
    parameter int PIX_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIX_W-1:0]      pix_in,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    output logic [TAPS*PIX_W-1:0] tap_data,
    output logic [7:0]            tap_row,
    output logic [7:0]            tap_col,
    output logic                  tap_valid,
    output logic                  tap_last,
    input  logic                  tap_ready
);

    localparam int         WIN    = NUM_PIXEL + 7;
    localparam int         IDX_W  = $clog2(WIN);
    localparam logic [7:0] WIN_M1 = 8'(WIN - 1);
    localparam logic [7:0] COL_M1 = 8'(NUM_PIXEL - 1);

`ifdef REF_WINDOW_LOADER_PING_PONG_EN
    localparam logic PING_PONG = 1'b1;
`else
    localparam logic PING_PONG = 1'b0;
`endif

    ld_state_t             state, state_n;
    logic [7:0]            ld_row, ld_col;
    logic [1:0]            full, full_n;
    logic                  wr_sel, wr_sel_n;
    logic                  rd_sel, rd_sel_n;
    logic                  pix_fire, fill_done, tap_fire, drain_done;
    logic                  start_next;
    logic                  load_first, advance, go_idle;
    logic                  pix_ready_n;
    logic [7:0]            rd_row_n, rd_col_n;
    logic [TAPS*PIX_W-1:0] rd_tap;

    assign pix_fire   = pix_valid & pix_ready;
    assign fill_done  = pix_fire && (ld_row == WIN_M1) && (ld_col == WIN_M1);
    assign tap_fire   = tap_valid & tap_ready;
    assign drain_done = tap_fire & tap_last;

    // A bank stays full from its last pixel until its tap_last handshake.
    always_comb begin
        full_n = full;
        if (drain_done) begin
            full_n[rd_sel] = 1'b0;
        end
        if (fill_done) begin
            full_n[wr_sel] = 1'b1;
        end
        wr_sel_n   = wr_sel ^ (fill_done & PING_PONG);
        rd_sel_n   = rd_sel ^ (drain_done & PING_PONG);
        start_next = full_n[rd_sel_n];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (start_next) state_n = DRAIN;
            DRAIN:   if (drain_done && !start_next) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    // rd_row_n/rd_col_n address the tap registered at the next edge.
    always_comb begin
        load_first  = 1'b0;
        advance     = 1'b0;
        go_idle     = 1'b0;
        rd_row_n    = '0;
        rd_col_n    = '0;
        pix_ready_n = !full_n[wr_sel_n];
        case (state)
            LOAD: begin
                load_first = start_next;
            end
            DRAIN: begin
                if (tap_fire) begin
                    if (tap_last) begin
                        load_first = start_next;
                        go_idle    = !start_next;
                    end else begin
                        advance  = 1'b1;
                        rd_col_n = wrap_inc(tap_col, COL_M1);
                        rd_row_n = (tap_col == COL_M1) ? tap_row + 8'd1 : tap_row;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_row <= '0;
            ld_col <= '0;
            full   <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            full   <= full_n;
            wr_sel <= wr_sel_n;
            rd_sel <= rd_sel_n;
            if (pix_fire) begin
                ld_col <= wrap_inc(ld_col, WIN_M1);
                if (ld_col == WIN_M1) begin
                    ld_row <= wrap_inc(ld_row, WIN_M1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_ready <= 1'b0;
            tap_valid <= 1'b0;
            tap_last  <= 1'b0;
            tap_data  <= '0;
            tap_row   <= '0;
            tap_col   <= '0;
        end else begin
            pix_ready <= pix_ready_n;
            if (load_first || advance) begin
                tap_valid <= 1'b1;
                tap_row   <= rd_row_n;
                tap_col   <= rd_col_n;
                tap_data  <= rd_tap;
                tap_last  <= advance && (rd_row_n == WIN_M1) && (rd_col_n == COL_M1);
            end else if (go_idle) begin
                tap_valid <= 1'b0;
                tap_last  <= 1'b0;
                tap_row   <= '0;
                tap_col   <= '0;
                tap_data  <= '0;
            end
        end
    end

`ifdef REF_WINDOW_LOADER_PING_PONG_EN
    logic [TAPS*PIX_W-1:0] bank0_tap, bank1_tap;

    window_bank #(.NUM_PIXEL(NUM_PIXEL), .PIX_W(PIX_W)) u_bank0 (
        .clk     (clk),
        .we      (pix_fire & ~wr_sel),
        .wr_row  (ld_row[IDX_W-1:0]),
        .wr_col  (ld_col[IDX_W-1:0]),
        .wr_data (pix_in),
        .rd_row  (rd_row_n[IDX_W-1:0]),
        .rd_col  (rd_col_n[IDX_W-1:0]),
        .rd_tap  (bank0_tap)
    );

    window_bank #(.NUM_PIXEL(NUM_PIXEL), .PIX_W(PIX_W)) u_bank1 (
        .clk     (clk),
        .we      (pix_fire & wr_sel),
        .wr_row  (ld_row[IDX_W-1:0]),
        .wr_col  (ld_col[IDX_W-1:0]),
        .wr_data (pix_in),
        .rd_row  (rd_row_n[IDX_W-1:0]),
        .rd_col  (rd_col_n[IDX_W-1:0]),
        .rd_tap  (bank1_tap)
    );

    assign rd_tap = rd_sel_n ? bank1_tap : bank0_tap;
`else
    window_bank #(.NUM_PIXEL(NUM_PIXEL), .PIX_W(PIX_W)) u_bank0 (
        .clk     (clk),
        .we      (pix_fire),
        .wr_row  (ld_row[IDX_W-1:0]),
        .wr_col  (ld_col[IDX_W-1:0]),
        .wr_data (pix_in),
        .rd_row  (rd_row_n[IDX_W-1:0]),
        .rd_col  (rd_col_n[IDX_W-1:0]),
        .rd_tap  (rd_tap)
    );
`endif

endmodule

// File: tb/tb_ref_window_loader.sv
// tb/tb_ref_window_loader.sv - scoreboard bench for ref_window_loader
`timescale 1ns/1ps
module tb_ref_window_loader;
    import subpel_pkg::*;

    localparam int NP  = 8;
    localparam int WIN = NP + 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    pixel_t     pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    tap_vec_t   tap_data;
    logic [7:0] tap_row, tap_col;
    logic       tap_valid, tap_last;
    logic       tap_ready = 1'b0;

    always #5 clk = ~clk;

    ref_window_loader #(.NUM_PIXEL(NP), .PIX_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .tap_data  (tap_data),
        .tap_row   (tap_row),
        .tap_col   (tap_col),
        .tap_valid (tap_valid),
        .tap_last  (tap_last),
        .tap_ready (tap_ready)
    );

    typedef struct packed {
        tap_vec_t   data;
        logic [7:0] row;
        logic [7:0] col;
        logic       last;
    } tap_t;

    tap_t     exp_q[$];
    tap_vec_t obs  [WIN][NP];
    tap_vec_t obs1 [WIN][NP];
    int vectors = 0, miscompares = 0;
    int n_taps = 0, n_last = 0;
    int rdy_mode = 0;

    function automatic pixel_t pix_val(input bit inv, input int r, input int c);
        pixel_t v;
        v = 8'(r * 16 + c);
        return inv ? ~v : v;
    endfunction

    function automatic tap_t exp_tap(input bit inv, input int r, input int c);
        tap_t t;
        t.data = '0;
        for (int k = 0; k < 8; k++) t.data[8*k +: 8] = pix_val(inv, r, c + k);
        t.row  = 8'(r);
        t.col  = 8'(c);
        t.last = (r == WIN - 1) && (c == NP - 1);
        return t;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < NP; c++) obs[r][c] = '0;
    endtask

    // Monitor: pops the scoreboard on every handshake, checks stall stability.
    initial begin
        tap_t cur, held;
        bit   stalled;
        stalled = 0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {tap_data, tap_row, tap_col, tap_last};
            if (reset || !tap_valid) begin
                stalled = 0;
            end else begin
                if (stalled) check("stall_hold", cur, held);
                if (tap_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_tap: got %0h, expected no tap", cur);
                    end else begin
                        check("tap", cur, exp_q.pop_front());
                    end
`ifndef REF_WINDOW_LOADER_PING_PONG_EN
                    check("pix_ready_in_drain", pix_ready, 0);
`endif
                    if (tap_row < 8'(WIN) && tap_col < 8'(NP)) obs[tap_row][tap_col] = tap_data;
                    n_taps++;
                    if (tap_last) n_last++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    held = cur;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tap_ready = (rdy_mode == 0) ? 1'b1 : ~tap_ready;
        end
    end

    task automatic load_window(input bit inv, input bit gaps, input int n_pix);
        if (n_pix == WIN * WIN) begin
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < NP; c++) exp_q.push_back(exp_tap(inv, r, c));
        end
        for (int i = 0; i < n_pix; i++) begin
            int guard;
            bit acc;
            guard = 0;
            acc = 0;
            pix_in = pix_val(inv, i / WIN, i % WIN);
            while (!acc) begin
                pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                acc = pix_valid && pix_ready;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 2000) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL load_timeout: got no accept of pixel %0d, expected accept within 2000 cycles", i);
                    pix_valid = 1'b0;
                    return;
                end
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while ((exp_q.size() != 0 || tap_valid) && g < 4000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("drain_complete", g < 4000, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        check("reset_outputs_zero", {pix_ready, tap_valid, tap_last, tap_data, tap_row, tap_col}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, g, diff;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {pix_ready, tap_valid, tap_last, tap_data, tap_row, tap_col}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("pix_ready_before_edge", pix_ready, 0);
        @(negedge clk);
        check("pix_ready_after_edge", pix_ready, 1);
        @(posedge clk);
        #1;

        // 1: basic fill and drain
        rdy_mode = 0;
        clear_obs();
        base = n_taps;
        load_window(0, 0, WIN * WIN);
        check("first_tap_latency", tap_valid, 1);
`ifndef REF_WINDOW_LOADER_PING_PONG_EN
        check("pix_ready_drop", pix_ready, 0);
`endif
        wait_drain();
        check("tap_count_t1", n_taps - base, 120);
        check("tap_0_0", obs[0][0], 64'h0706050403020100);
        check("tap_3_2", obs[3][2], 64'h3938373635343332);
        check("tap_14_7", obs[14][7], 64'hEEEDECEBEAE9E8E7);
        obs1 = obs;

        // 2: back-pressure
        rdy_mode = 1;
        clear_obs();
        base = n_taps;
        load_window(0, 0, WIN * WIN);
        wait_drain();
        check("tap_count_t2", n_taps - base, 120);
        rdy_mode = 0;

        // 3: source gaps
        clear_obs();
        base = n_taps;
        load_window(0, 1, WIN * WIN);
        wait_drain();
        check("tap_count_t3", n_taps - base, 120);
        diff = 0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < NP; c++) if (obs[r][c] !== obs1[r][c]) diff++;
        check("gap_window_match", diff, 0);

        // 4: mid-operation reset
        load_window(0, 0, 100);
        pulse_reset();
        rdy_mode = 1;
        base = n_taps;
        load_window(0, 0, WIN * WIN);
        g = 0;
        while (n_taps - base < 40 && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("taps_before_reset", n_taps - base, 40);
        pulse_reset();
        rdy_mode = 0;
        clear_obs();
        load_window(0, 0, WIN * WIN);
        wait_drain();
        check("fresh_tap_0_0", obs[0][0], 64'h0706050403020100);

        // 5: back-to-back windows
`ifdef REF_WINDOW_LOADER_PING_PONG_EN
        rdy_mode = 1;
`endif
        clear_obs();
        base = n_last;
        fork
            begin
                load_window(0, 0, WIN * WIN);
                load_window(1, 0, WIN * WIN);
            end
            begin
                int w;
                w = 0;
                while (n_last == base && w < 4000) begin
                    @(posedge clk);
                    #1;
                    w++;
                end
`ifdef REF_WINDOW_LOADER_PING_PONG_EN
                check("no_bubble", {tap_valid, tap_row, tap_col}, {1'b1, 16'h0000});
`else
                check("ready_after_last", {pix_ready, tap_valid}, 2'b10);
`endif
            end
        join
        wait_drain();
        rdy_mode = 0;
        check("w2_tap_0_0", obs[0][0], 64'hF8F9FAFBFCFDFEFF);
        check("w2_tap_14_7", obs[14][7], 64'h1112131415161718);
        check("last_count_t5", n_last - base, 2);

        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1);
    end

endmodule
